// File: rtl/bcd_serial_addsub.sv
// Digit-serial N-digit packed-BCD adder/subtractor: one corrected BCD digit slice
// reused over DIGITS clocks under a start/busy/done handshake.
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  cin,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  cout,
  output logic                  invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [KW-1:0] KLAST = KW'(DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Returns {carry_out, corrected_digit}; s may reach 31 for non-BCD inputs.
  function automatic logic [4:0] bcd_digit(input logic [3:0] x, input logic [3:0] y,
                                           input logic c);
    logic [4:0] s;
    s = {1'b0, x} + {1'b0, y} + {4'd0, c};
    if (s > 5'd9) begin
      s = s + 5'd6;
      return {1'b1, s[3:0]};
    end
    return {1'b0, s[3:0]};
  endfunction

  function automatic logic [W-1:0] nines_comp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'd9 - v[4*i +: 4];
    return r;
  endfunction

  function automatic logic has_bad(input logic [W-1:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) r = 1'b1;
    return r;
  endfunction

  state_t          state, state_nxt;
  logic [W-1:0]    opa, opb, acc, acc_nxt;
  logic            carry;
  logic [KW-1:0]   k;
  logic [3:0]      opa_k, opb_k;
  logic [4:0]      slice;
  logic            accept, last;

  assign accept = start && (state != S_RUN);
  assign last   = (k == KLAST);
  assign opa_k  = opa[{k, 2'b00} +: 4];
  assign opb_k  = opb[{k, 2'b00} +: 4];
  assign slice  = bcd_digit(opa_k, opb_k, carry);
  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);

  // The final digit is merged here so result is loaded complete on the last RUN edge.
  always_comb begin
    acc_nxt = acc;
    acc_nxt[{k, 2'b00} +: 4] = slice[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Subtraction is done as A + nines(B) + ~borrow, so cout doubles as "no borrow".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa     <= '0;
      opb     <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      k       <= '0;
      result  <= '0;
      cout    <= 1'b0;
      invalid <= 1'b0;
    end else if (accept) begin
      opa     <= a;
      opb     <= mode ? nines_comp(b) : b;
      carry   <= mode ? ~cin : cin;
      k       <= '0;
      invalid <= has_bad(a) | has_bad(b);
    end else if (state == S_RUN) begin
      acc   <= acc_nxt;
      carry <= slice[4];
      if (last) begin
        k      <= '0;
        result <= acc_nxt;
        cout   <= slice[4];
      end else begin
        k <= k + 1'b1;
      end
    end
  end

endmodule
